// File: rtl/io_port_pkg.sv
// Shared defaults for the IO port controller: bus width, outport FIFO depth
// and the pointer width derived from that depth.
package io_port_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int OUT_DEPTH_DEF = 4;

   // Pointer width for a power-of-two FIFO depth (depth >= 2).
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   localparam int PTR_W_DEF = ptr_w(OUT_DEPTH_DEF);

endpackage

// File: rtl/io_port_controller_sync_fifo.sv
// Synchronous FIFO for the outport path. Pointers wrap naturally because the
// depth is a power of two; a push while full is only taken alongside a pop.
module sync_fifo
   import io_port_pkg::*;
#(
   parameter int W     = DATA_W_DEF,
   parameter int DEPTH = OUT_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic                     full,
   output logic                     empty,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = ptr_w(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign count = cnt_q;
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/io_port_controller.sv
// CPU IO port controller: edge-detected outport strobe feeding a FIFO toward
// an external sink, and a single-word holding register from an external source.
module io_port_controller
   import io_port_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              outport_enable,
   input  logic [DATA_W-1:0] outport_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_overflow,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] inport_in,
   input  logic              inport_out,
   output logic              in_full
);

   localparam int PTR_W = ptr_w(OUT_DEPTH);

   // valid/ready: a word moves when valid & ready are both high at a rising
   // clock edge; valid never waits on ready, and data holds while valid & ~ready.

   logic              en_prev_q, en_prev_d;
   logic              cons_prev_q, cons_prev_d;
   logic              overflow_q, overflow_d;
   logic              in_full_q, in_full_d;
   logic [DATA_W-1:0] inport_q, inport_d;
   logic              write_ev, consume_ev, accept;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic [PTR_W:0]    fifo_count;
   logic              unused_fifo_count;

   assign write_ev          = outport_enable & ~en_prev_q;
   assign consume_ev        = inport_out & ~cons_prev_q;
   assign out_valid         = ~fifo_empty;
   assign fifo_pop          = out_valid & out_ready;
   assign in_ready          = ~in_full_q;
   assign accept            = in_valid & in_ready;
   assign in_full           = in_full_q;
   assign inport_in         = inport_q;
   assign out_overflow      = overflow_q;
   assign unused_fifo_count = ^fifo_count;

   always_comb begin
      en_prev_d   = outport_enable;
      cons_prev_d = inport_out;
      // A full FIFO only drops the word when nothing leaves in the same cycle.
      overflow_d  = overflow_q | (write_ev & fifo_full & ~fifo_pop);
      in_full_d   = in_full_q;
      inport_d    = inport_q;
      if (consume_ev && in_full_q) begin
         in_full_d = 1'b0;
      end else if (accept) begin
         in_full_d = 1'b1;
         inport_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         en_prev_q   <= 1'b0;
         cons_prev_q <= 1'b0;
         overflow_q  <= 1'b0;
         in_full_q   <= 1'b0;
         inport_q    <= '0;
      end else begin
         en_prev_q   <= en_prev_d;
         cons_prev_q <= cons_prev_d;
         overflow_q  <= overflow_d;
         in_full_q   <= in_full_d;
         inport_q    <= inport_d;
      end
   end

   sync_fifo #(
      .W     (DATA_W),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk   (clk),
      .rst_n (clr),
      .push  (write_ev),
      .pop   (fifo_pop),
      .din   (outport_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (out_data),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: outport FIFO fill/drain/overflow,
// inport holding register, and asynchronous reset mid-operation.
module tb_io_port_controller;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic         outport_enable = 1'b0;
   logic [W-1:0] outport_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_overflow;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic [W-1:0] inport_in;
   logic         inport_out = 1'b0;
   logic         in_full;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_port_controller #(.DATA_W(W), .OUT_DEPTH(4)) dut (
      .clk            (clk),
      .clr            (clr),
      .outport_enable (outport_enable),
      .outport_data   (outport_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_overflow   (out_overflow),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .inport_in      (inport_in),
      .inport_out     (inport_out),
      .in_full        (in_full)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [W-1:0] d);
      outport_data   = d;
      outport_enable = 1'b1;
      step();
      outport_enable = 1'b0;
      step();
   endtask

   task automatic pulse_reset();
      clr = 1'b0;
      #2;
      clr = 1'b1;
   endtask

   initial begin
      // Reset values
      #3;
      check("rst_out_valid", W'(out_valid), 0);
      check("rst_out_data", out_data, 0);
      check("rst_overflow", W'(out_overflow), 0);
      check("rst_in_ready", W'(in_ready), 1);
      check("rst_in_full", W'(in_full), 0);
      check("rst_inport_in", inport_in, 0);
      step();
      clr = 1'b1;
      step();

      // Single write, strobe held two cycles
      outport_data   = 32'h0000ABCD;
      outport_enable = 1'b1;
      #1;
      check("wr1_valid_event_cycle", W'(out_valid), 0);
      step();
      check("wr1_valid", W'(out_valid), 1);
      check("wr1_data", out_data, 32'h0000ABCD);
      step();
      outport_enable = 1'b0;
      out_ready      = 1'b1;
      check("wr1_still_one", out_data, 32'h0000ABCD);
      step();
      check("wr1_single_entry", W'(out_valid), 0);
      out_ready = 1'b0;
      step();

      // Five writes into depth 4: fifth dropped, drain 1..4 back to back
      for (int i = 1; i <= 5; i++) write_word(W'(i));
      check("ovf_set", W'(out_overflow), 1);
      check("ovf_head", out_data, 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovf_drain_valid%0d", i), W'(out_valid), 1);
         check($sformatf("ovf_drain%0d", i), out_data, W'(i));
         step();
      end
      check("ovf_drained_empty", W'(out_valid), 0);
      check("ovf_sticky", W'(out_overflow), 1);
      out_ready = 1'b0;

      // Full FIFO with simultaneous pop and push: no overflow
      pulse_reset();
      check("rst2_overflow", W'(out_overflow), 0);
      step();
      write_word(32'h11);
      write_word(32'h22);
      write_word(32'h33);
      write_word(32'h44);
      outport_data   = 32'h55;
      outport_enable = 1'b1;
      out_ready      = 1'b1;
      step();
      outport_enable = 1'b0;
      out_ready      = 1'b0;
      check("fullpp_no_ovf", W'(out_overflow), 0);
      check("fullpp_head", out_data, 32'h22);
      step();
      check("fullpp_head_stable", out_data, 32'h22);
      out_ready = 1'b1;
      check("fullpp_d22", out_data, 32'h22); step();
      check("fullpp_d33", out_data, 32'h33); step();
      check("fullpp_d44", out_data, 32'h44); step();
      check("fullpp_d55", out_data, 32'h55); step();
      check("fullpp_empty", W'(out_valid), 0);
      out_ready = 1'b0;

      // Inport: accept, stall second word, consume, accept next
      in_data  = 32'h1234;
      in_valid = 1'b1;
      #1;
      check("in_ready_idle", W'(in_ready), 1);
      step();
      check("in_full_set", W'(in_full), 1);
      check("in_ready_low", W'(in_ready), 0);
      check("in_word1", inport_in, 32'h1234);
      in_data = 32'h9999;
      step();
      check("in_stall_full", W'(in_full), 1);
      check("in_stall_data", inport_in, 32'h1234);
      inport_out = 1'b1;
      step();
      check("in_consumed", W'(in_full), 0);
      check("in_consumed_keep", inport_in, 32'h1234);
      step();
      check("in_word2_full", W'(in_full), 1);
      check("in_word2", inport_in, 32'h9999);
      in_valid = 1'b0;
      step();
      check("in_held_strobe_once", W'(in_full), 1);
      inport_out = 1'b0;
      step();
      inport_out = 1'b1;
      step();
      inport_out = 1'b0;
      check("in_consume2", W'(in_full), 0);
      step();

      // Consume pulse while empty: ignored
      inport_out = 1'b1;
      step();
      inport_out = 1'b0;
      step();
      check("in_idle_consume_full", W'(in_full), 0);
      check("in_idle_consume_data", inport_in, 32'h9999);

      // Reset mid-drain with three words buffered and overflow set
      for (int i = 1; i <= 5; i++) write_word(W'(32'hA0 + i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("mid_head", out_data, 32'hA2);
      check("mid_ovf", W'(out_overflow), 1);
      outport_data   = 32'h77;
      outport_enable = 1'b1;
      clr            = 1'b0;
      #1;
      check("async_valid", W'(out_valid), 0);
      check("async_ovf", W'(out_overflow), 0);
      check("async_data", out_data, 0);
      check("async_inport", inport_in, 0);
      check("async_in_ready", W'(in_ready), 1);
      #2;
      clr = 1'b1;
      check("post_rst_empty", W'(out_valid), 0);
      step();
      check("post_rst_event", W'(out_valid), 1);
      check("post_rst_data", out_data, 32'h77);
      outport_enable = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
